// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: arbiter states
// and the default starvation limit for queued MDU results.
package regfile_write_arbiter_pkg;

    typedef enum logic {
        PRI   = 1'b0,
        FORCE = 1'b1
    } arb_state_e;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the pipeline/MDU sources and the register-file write
// arbiter, including the registered write port and status.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADR_W  = 5
);
    logic              wbValid;
    logic [ADR_W-1:0]  wbAdr;
    logic [DATA_W-1:0] wbData;
    logic              wbReady;
    logic              mduValid;
    logic [ADR_W-1:0]  mduAdr;
    logic [DATA_W-1:0] mduData;
    logic              mduReady;
    logic              regWrite;
    logic [ADR_W-1:0]  writeAdr;
    logic [DATA_W-1:0] writeData;
    logic [1:0]        fifoCount;
    logic              forceActive;

    modport master (
        output wbValid, wbAdr, wbData, mduValid, mduAdr, mduData,
        input  wbReady, mduReady, regWrite, writeAdr, writeData, fifoCount, forceActive
    );

    modport slave (
        input  wbValid, wbAdr, wbData, mduValid, mduAdr, mduData,
        output wbReady, mduReady, regWrite, writeAdr, writeData, fifoCount, forceActive
    );
endinterface

// File: rtl/regfile_write_arbiter_wb_fifo2.sv
// Two-entry in-order FIFO; entry 0 is always the head. The caller never
// pushes when full nor pops when empty.
module wb_fifo2 #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic [1:0]   r_count;
    logic         w_wr_idx;

    // After a pop the entries shift down, so the write slot follows the post-pop count.
    assign w_wr_idx = (r_count == 2'd1) && !i_pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count  <= 2'd0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else begin
            if (i_pop)
                r_mem[0] <= r_mem[1];
            if (i_push)
                r_mem[w_wr_idx] <= i_data;
            r_count <= r_count + 2'(i_push) - 2'(i_pop);
        end
    end

    assign o_data  = r_mem[0];
    assign o_count = r_count;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// and queued MDU results, forcing an MDU write when it has waited too long.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADR_W      = 5,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    regfile_write_arbiter_if.slave bus
);
    localparam int ENT_W = ADR_W + DATA_W;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_starve, w_starve_nxt;
    logic              r_regWrite;
    logic [ADR_W-1:0]  r_writeAdr;
    logic [DATA_W-1:0] r_writeData;

    logic [1:0]        w_count;
    logic [ENT_W-1:0]  w_head;
    logic              w_fifo_ne, w_force, w_pop, w_push, w_grant_wb, w_grant, w_wr_en;
    logic [ADR_W-1:0]  w_adr;
    logic [DATA_W-1:0] w_data;

    assign w_fifo_ne  = (w_count != 2'd0);
    assign w_force    = (r_state == FORCE);
    assign w_pop      = rst && w_fifo_ne && (w_force || !bus.wbValid);
    assign w_grant_wb = rst && !w_force && bus.wbValid;
    assign w_grant    = w_pop || w_grant_wb;
    assign w_push     = bus.mduValid && bus.mduReady;

    assign bus.wbReady  = rst && !w_force;
    assign bus.mduReady = rst && (w_count < 2'd2);

    assign {w_adr, w_data} = w_pop ? w_head : {bus.wbAdr, bus.wbData};
    // Address 0 is hardwired: the request is consumed but never written.
    assign w_wr_en = w_grant && (w_adr != '0);

    wb_fifo2 #(.W(ENT_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({bus.mduAdr, bus.mduData}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    always_comb begin
        w_starve_nxt = r_starve;
        w_state_nxt  = r_state;
        if (!w_fifo_ne || w_pop)
            w_starve_nxt = '0;
        else if (r_starve != CNT_W'(STARVE_MAX))
            w_starve_nxt = r_starve + 1'b1;
        case (r_state)
            PRI:     if (w_fifo_ne && !w_pop && r_starve == CNT_W'(STARVE_MAX - 1))
                         w_state_nxt = FORCE;
            FORCE:   if (w_pop || !w_fifo_ne)
                         w_state_nxt = PRI;
            default: w_state_nxt = PRI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= PRI;
            r_starve    <= '0;
            r_regWrite  <= 1'b0;
            r_writeAdr  <= '0;
            r_writeData <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_starve   <= w_starve_nxt;
            r_regWrite <= w_wr_en;
            if (w_wr_en) begin
                r_writeAdr  <= w_adr;
                r_writeData <= w_data;
            end
        end
    end

    assign bus.regWrite    = r_regWrite;
    assign bus.writeAdr    = r_writeAdr;
    assign bus.writeData   = r_writeData;
    assign bus.fifoCount   = w_count;
    assign bus.forceActive = w_force;
endmodule
